// File: rtl/tt_sweep_ctrl.sv
// Exhaustive 4-input truth-table sweeper: drives every vector, compares the response against EXPECTED.
// Optional macro TT_SWEEP_CTRL_SYNC_EN adds a two-flop synchronizer on dut_out and extends each hold by 2 cycles.
module tt_sweep_ctrl #(
  parameter logic [15:0] EXPECTED      = 16'h3B60,
  parameter int          SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop_on_fail,
  output logic        in1,
  output logic        in2,
  output logic        in3,
  output logic        in4,
  input  logic        dut_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] mismatch_mask,
  output logic [3:0]  fail_index
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  idx_r;
  logic [8:0]  cnt_r;
  logic        sof_r;
  logic [15:0] mask_r;
  logic [3:0]  fail_idx_r;
  logic        pass_r;
  logic        done_r;
  logic        busy_r;
  logic        busy_nxt_s;
  logic        done_nxt_s;
  logic        resp_s;
  logic        mism_s;

`ifdef TT_SWEEP_CTRL_SYNC_EN
  // Two extra hold cycles cover the synchronizer latency before SAMPLE.
  localparam logic [8:0] CNT_LAST = 9'(SETTLE_CYCLES + 1);
  logic [1:0] sync_r;

  // Two-flop synchronizer for the response of the function under test
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], dut_out};
    end
  end

  assign resp_s = sync_r[1];
`else
  localparam logic [8:0] CNT_LAST = 9'(SETTLE_CYCLES - 1);

  assign resp_s = dut_out;
`endif

  assign mism_s = (resp_s != EXPECTED[idx_r]);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = DRIVE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRIVE: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = SAMPLE;
        end else begin
          state_nxt_s = DRIVE;
        end
      end
      SAMPLE: begin
        if ((idx_r == 4'd15) || (mism_s && sof_r)) begin
          state_nxt_s = FINISH;
        end else begin
          state_nxt_s = DRIVE;
        end
      end
      FINISH:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode, registered below so busy/done line up with the state they describe
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (state_nxt_s)
      IDLE: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
      DRIVE, SAMPLE: begin
        busy_nxt_s = 1'b1;
        done_nxt_s = 1'b0;
      end
      FINISH: begin
        busy_nxt_s = 1'b1;
        done_nxt_s = 1'b1;
      end
      default: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath and registered outputs; pass is resolved on entry to FINISH so it is valid alongside done
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r      <= 4'd0;
      cnt_r      <= 9'd0;
      sof_r      <= 1'b0;
      mask_r     <= 16'h0000;
      fail_idx_r <= 4'd0;
      pass_r     <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
      case (state_r)
        IDLE: begin
          if (start) begin
            idx_r      <= 4'd0;
            cnt_r      <= 9'd0;
            mask_r     <= 16'h0000;
            fail_idx_r <= 4'd0;
            sof_r      <= stop_on_fail;
          end
        end
        DRIVE: begin
          cnt_r <= cnt_r + 9'd1;
        end
        SAMPLE: begin
          if (mism_s) begin
            mask_r[idx_r] <= 1'b1;
            if (mask_r == 16'h0000) begin
              fail_idx_r <= idx_r;
            end
          end
          if (state_nxt_s == DRIVE) begin
            idx_r <= idx_r + 4'd1;
            cnt_r <= 9'd0;
          end
          if (state_nxt_s == FINISH) begin
            pass_r <= (mask_r == 16'h0000) && !mism_s;
          end
        end
        FINISH: begin
          cnt_r <= 9'd0;
        end
        default: begin
          cnt_r <= 9'd0;
        end
      endcase
    end
  end

  assign in1           = idx_r[3];
  assign in2           = idx_r[2];
  assign in3           = idx_r[1];
  assign in4           = idx_r[0];
  assign busy          = busy_r;
  assign done          = done_r;
  assign pass          = pass_r;
  assign mismatch_mask = mask_r;
  assign fail_index    = fail_idx_r;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Directed bench for tt_sweep_ctrl: golden-model, stuck-at-0, single-flip, reset and re-start scenarios.
module tb_tt_sweep_ctrl;

`ifdef TT_SWEEP_CTRL_SYNC_EN
  localparam int SETTLE = 1;
  localparam int HOLD   = SETTLE + 3;
`else
  localparam int SETTLE = 4;
  localparam int HOLD   = SETTLE + 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop_on_fail;
  logic        in1, in2, in3, in4;
  logic        dut_out;
  logic        busy, done, pass;
  logic [15:0] mismatch_mask;
  logic [3:0]  fail_index;

  logic [15:0] golden = 16'h3B60;
  logic [3:0]  vec;
  int          mode;
  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cyc;
  int          n_done;

  tt_sweep_ctrl #(.EXPECTED(16'h3B60), .SETTLE_CYCLES(SETTLE)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stop_on_fail(stop_on_fail),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass),
    .mismatch_mask(mismatch_mask), .fail_index(fail_index)
  );

  always #5 clk = ~clk;

  // Function under test: 0 = golden table, 1 = stuck at 0, 2 = golden with vector 10 inverted
  assign vec     = {in1, in2, in3, in4};
  assign dut_out = (mode == 0) ? golden[vec] :
                   (mode == 1) ? 1'b0 : (golden[vec] ^ (vec == 4'd10));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pulses start, then observes cycles 1..ncyc after the accepted start edge
  task automatic sweep(input logic sof, input bit repulse, input bit chk_vec, input int ncyc,
                       output int dcyc, output int ndone);
    dcyc  = 0;
    ndone = 0;
    @(negedge clk);
    start        = 1'b1;
    stop_on_fail = sof;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (chk_vec && c <= 16 * HOLD) check("vec", 32'(vec), 32'((c - 1) / HOLD));
      if (done) begin
        ndone++;
        if (dcyc == 0) dcyc = c;
      end
      if (repulse && (c == 20 || done)) start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop_on_fail = 1'b0; mode = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_mask", 32'(mismatch_mask), 32'd0);
    check("rst_fidx", 32'(fail_index), 32'd0);
    check("rst_vec", 32'(vec), 32'd0);
    rst = 1'b0;

    // Golden sweep with start re-pulsed mid-sweep and during FINISH
    mode = 0;
    sweep(1'b0, 1'b1, 1'b1, 16 * HOLD + 20, done_cyc, n_done);
    check("ok_done_cyc", 32'(done_cyc), 32'(16 * HOLD + 1));
    check("ok_n_done", 32'(n_done), 32'd1);
    check("ok_busy_after", 32'(busy), 32'd0);
    check("ok_pass", 32'(pass), 32'd1);
    check("ok_mask", 32'(mismatch_mask), 32'h0000);
    check("ok_fidx", 32'(fail_index), 32'd0);
    check("ok_idle_vec", 32'(vec), 32'hF);

    // Stuck-at-0, full sweep
    mode = 1;
    sweep(1'b0, 1'b0, 1'b0, 16 * HOLD + 5, done_cyc, n_done);
    check("s0_done_cyc", 32'(done_cyc), 32'(16 * HOLD + 1));
    check("s0_pass", 32'(pass), 32'd0);
    check("s0_mask", 32'(mismatch_mask), 32'h3B60);
    check("s0_fidx", 32'(fail_index), 32'd5);

    // Stuck-at-0 with stop_on_fail: ends after vector 5 sample
    sweep(1'b1, 1'b0, 1'b0, 16 * HOLD + 5, done_cyc, n_done);
    check("sof_done_cyc", 32'(done_cyc), 32'(6 * HOLD + 1));
    check("sof_n_done", 32'(n_done), 32'd1);
    check("sof_pass", 32'(pass), 32'd0);
    check("sof_mask", 32'(mismatch_mask), 32'h0020);
    check("sof_fidx", 32'(fail_index), 32'd5);
    check("sof_idle_vec", 32'(vec), 32'd5);

    // Single flip at vector 10
    mode = 2;
    sweep(1'b0, 1'b0, 1'b0, 16 * HOLD + 5, done_cyc, n_done);
    check("flip_pass", 32'(pass), 32'd0);
    check("flip_mask", 32'(mismatch_mask), 32'h0400);
    check("flip_fidx", 32'(fail_index), 32'd10);

    // Golden sweep to set pass=1, then reset in the middle of the next sweep at vector 7
    mode = 0;
    sweep(1'b0, 1'b0, 1'b0, 16 * HOLD + 5, done_cyc, n_done);
    check("pre_pass", 32'(pass), 32'd1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7 * HOLD + 1) @(negedge clk);
    check("mid_vec7", 32'(vec), 32'd7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_done", 32'(done), 32'd0);
    check("mr_pass", 32'(pass), 32'd0);
    check("mr_mask", 32'(mismatch_mask), 32'd0);
    check("mr_fidx", 32'(fail_index), 32'd0);
    check("mr_vec", 32'(vec), 32'd0);
    n_done = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("mr_no_done", 32'(n_done), 32'd0);

    // rst wins over start in the same cycle
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rs_busy", 32'(busy), 32'd0);

    // Normal sweep after reset
    sweep(1'b0, 1'b0, 1'b1, 16 * HOLD + 5, done_cyc, n_done);
    check("post_done_cyc", 32'(done_cyc), 32'(16 * HOLD + 1));
    check("post_pass", 32'(pass), 32'd1);
    check("post_mask", 32'(mismatch_mask), 32'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
